prio_readout_ctrl: RTL and testbench



---
 rtl/prio_readout_pkg.sv | 27 ++
 rtl/sel_delay_pipe.sv | 39 +++
 rtl/prio_readout_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_prio_readout_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_readout_pkg.sv
// Shared definitions for the readout controller: memory count, sel codes and FSM states.
`timescale 1ns/1ps
package prio_readout_pkg;

    localparam int N_MEM = 12;
    localparam logic [3:0] SEL_IDLE = 4'h0;
    localparam logic [3:0] SEL_HDR  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        READ = 2'd2
    } state_e;

    // Codes 0xA and 0xE are reserved on the mux, so memories 9..11 skip over 0xA.
    function automatic logic [3:0] sel_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd9:    code = 4'hB;
            4'd10:   code = 4'hC;
            4'd11:   code = 4'hD;
            default: code = (idx <= 4'd8) ? (idx + 4'd1) : SEL_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sel_delay_pipe.sv
// Fixed-depth register pipe that delays {BX, sel} to line up with memory read data.
`timescale 1ns/1ps
module sel_delay_pipe #(
    parameter int W     = 7,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Shift each stage one step down the pipe.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipe registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/prio_readout_ctrl.sv
// Snapshot entry counts per BX, emit a header slot, then issue one priority-selected read per cycle.
// Define ROUND_ROBIN_EN to rotate the priority search base after every grant.
`timescale 1ns/1ps
module prio_readout_ctrl
    import prio_readout_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1,
    parameter int WINDOW = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_MEM*ADDR_W-1:0] nent,
    output logic [N_MEM-1:0]        rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    output logic [3:0]              sel,
    output logic [2:0]              BX,
    output logic                    busy,
    output logic                    truncated
);

    localparam int CNT_W = $clog2(WINDOW + 1);

    state_e                  state_q, state_d;
    logic [N_MEM*ADDR_W-1:0] snap_q, snap_d;
    logic [ADDR_W-1:0]       ptr_q [N_MEM];
    logic [ADDR_W-1:0]       ptr_d [N_MEM];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              bx_q, bx_d;
    logic [3:0]              base_q, base_d;
    logic [N_MEM-1:0]        rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic                    busy_q, busy_d;
    logic                    trunc_q, trunc_d;
    logic [3:0]              sel_pre_q, sel_pre_d;
    logic [2:0]              bx_pre_q, bx_pre_d;
    logic [N_MEM-1:0]        pend_s;
    logic                    gnt_vld_s;
    logic [3:0]              gnt_idx_s;
    logic [6:0]              pipe_out_s;

    // Memories that still hold unread entries; ADDR_W-bit compare keeps pointers from wrapping.
    always_comb begin
        pend_s = '0;
        for (int i = 0; i < N_MEM; i++) begin
            pend_s[i] = ptr_q[i] < snap_q[i*ADDR_W +: ADDR_W];
        end
    end

    // First pending memory at or after the search base, wrapping past the last memory.
    always_comb begin
        logic [4:0] cand;
        gnt_vld_s = 1'b0;
        gnt_idx_s = 4'd0;
        cand      = 5'd0;
        for (int k = 0; k < N_MEM; k++) begin
            cand = 5'(base_q) + 5'(k);
            if (cand >= 5'(N_MEM)) begin
                cand = cand - 5'(N_MEM);
            end else begin
                cand = cand;
            end
            if (!gnt_vld_s && pend_s[cand[3:0]]) begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = cand[3:0];
            end else begin
                gnt_vld_s = gnt_vld_s;
            end
        end
    end

    // Next-state and registered-output logic; start overrides whatever the FSM would do.
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        bx_d      = bx_q;
        base_d    = base_q;
        rd_en_d   = '0;
        rd_addr_d = '0;
        busy_d    = busy_q;
        trunc_d   = 1'b0;
        sel_pre_d = SEL_IDLE;
        bx_pre_d  = bx_q;
        if (start) begin
            snap_d = nent;
            for (int i = 0; i < N_MEM; i++) begin
                ptr_d[i] = '0;
            end
            cnt_d   = '0;
            bx_d    = bx_q + 3'd1;
            base_d  = 4'd0;
            busy_d  = 1'b1;
            state_d = HDR;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_d = 1'b0;
                end
                HDR: begin
                    sel_pre_d = SEL_HDR;
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = READ;
                end
                READ: begin
                    if (!gnt_vld_s) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (cnt_q >= CNT_W'(WINDOW)) begin
                        trunc_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        rd_en_d            = {{(N_MEM-1){1'b0}}, 1'b1} << gnt_idx_s;
                        rd_addr_d          = ptr_q[gnt_idx_s];
                        ptr_d[gnt_idx_s]   = ptr_q[gnt_idx_s] + ADDR_W'(1);
                        sel_pre_d          = sel_code(gnt_idx_s);
                        cnt_d              = cnt_q + CNT_W'(1);
`ifdef ROUND_ROBIN_EN
                        base_d = (gnt_idx_s == 4'(N_MEM - 1)) ? 4'd0 : (gnt_idx_s + 4'd1);
`else
                        base_d = 4'd0;
`endif
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            for (int i = 0; i < N_MEM; i++) begin
                ptr_q[i] <= '0;
            end
            cnt_q     <= '0;
            bx_q      <= 3'd0;
            base_q    <= 4'd0;
            rd_en_q   <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            trunc_q   <= 1'b0;
            sel_pre_q <= SEL_IDLE;
            bx_pre_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            for (int i = 0; i < N_MEM; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
            cnt_q     <= cnt_d;
            bx_q      <= bx_d;
            base_q    <= base_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            trunc_q   <= trunc_d;
            sel_pre_q <= sel_pre_d;
            bx_pre_q  <= bx_pre_d;
        end
    end

    sel_delay_pipe #(
        .W     (7),
        .DEPTH (RD_LAT)
    ) u_sel_delay_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({bx_pre_q, sel_pre_q}),
        .dout  (pipe_out_s)
    );

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign busy      = busy_q;
    assign truncated = trunc_q;
    assign sel       = pipe_out_s[3:0];
    assign BX        = pipe_out_s[6:4];

endmodule

// File: tb/tb_prio_readout_ctrl.sv
// Randomised bench for prio_readout_ctrl: a transaction-level schedule model predicts every output per cycle.
`timescale 1ns/1ps
module tb_prio_readout_ctrl;

    localparam int NM   = 12;
    localparam int AW   = 6;
    localparam int LAT  = 2;
    localparam int WIN  = 8;
    localparam int SIZE = 8192;
    localparam int HOR  = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [NM*AW-1:0] nent = '0;
    logic [NM-1:0]    rd_en;
    logic [AW-1:0]    rd_addr;
    logic [3:0]       sel;
    logic [2:0]       BX;
    logic             busy;
    logic             truncated;

    int checks = 0;
    int failures = 0;
    int t = 0;
    logic [2:0] bx_m = 3'd0;

    logic [NM-1:0] e_rden  [SIZE];
    logic [AW-1:0] e_addr  [SIZE];
    logic          e_busy  [SIZE];
    logic          e_trunc [SIZE];
    logic [3:0]    e_sel   [SIZE];
    logic [2:0]    e_bx    [SIZE];

    prio_readout_ctrl #(
        .ADDR_W (AW),
        .RD_LAT (LAT),
        .WINDOW (WIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .nent      (nent),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .sel       (sel),
        .BX        (BX),
        .busy      (busy),
        .truncated (truncated)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] exp_code(input int i);
        return (i < 9) ? 4'(i + 1) : 4'(i + 2);
    endfunction

    task automatic model_clear();
        for (int u = 0; u < SIZE; u++) begin
            e_rden[u] = '0; e_addr[u] = '0; e_busy[u] = 1'b0;
            e_trunc[u] = 1'b0; e_sel[u] = 4'h0; e_bx[u] = 3'd0;
        end
        bx_m = 3'd0;
        t = 0;
    endtask

    // Build the whole read schedule of a BX from its counts, then lay it out on the cycle timeline.
    task automatic model_start(input int t0, input logic [NM*AW-1:0] nv);
        int q_idx[$];
        int q_adr[$];
        int cnt[NM];
        int taken[NM];
        int n;
        bit more;
        logic [2:0] old_bx;
        for (int i = 0; i < NM; i++) begin
            cnt[i] = int'(nv[i*AW +: AW]);
            taken[i] = 0;
        end
`ifdef ROUND_ROBIN_EN
        more = 1'b1;
        while (more) begin
            more = 1'b0;
            for (int i = 0; i < NM; i++) begin
                if (taken[i] < cnt[i]) begin
                    q_idx.push_back(i); q_adr.push_back(taken[i]);
                    taken[i]++; more = 1'b1;
                end
            end
        end
`else
        more = 1'b0;
        for (int i = 0; i < NM; i++) begin
            for (int a = 0; a < cnt[i]; a++) begin
                q_idx.push_back(i); q_adr.push_back(a);
            end
        end
`endif
        old_bx = bx_m;
        bx_m = bx_m + 3'd1;
        n = (q_idx.size() < WIN - 1) ? q_idx.size() : WIN - 1;
        if (t0 + HOR < SIZE) begin
            for (int u = t0; u <= t0 + HOR; u++) begin
                e_rden[u] = '0; e_addr[u] = '0; e_busy[u] = 1'b0;
                e_trunc[u] = 1'b0; e_sel[u] = 4'h0; e_bx[u] = bx_m;
            end
            e_busy[t0] = 1'b1;
            e_bx[t0] = old_bx;
            e_busy[t0+1] = 1'b1;
            e_sel[t0+1] = 4'hF;
            for (int k = 0; k < n; k++) begin
                e_rden[t0+2+k] = NM'(1) << q_idx[k];
                e_addr[t0+2+k] = AW'(q_adr[k]);
                e_sel[t0+2+k]  = exp_code(q_idx[k]);
                e_busy[t0+2+k] = 1'b1;
            end
            e_trunc[t0+n+2] = (q_idx.size() > WIN - 1);
        end else begin
            check_eq("timeline_room", 32'(t0), 32'(SIZE - HOR - 1));
        end
    endtask

    task automatic check_cycle();
        int d;
        d = t - LAT;
        check_eq("rd_en", 32'(rd_en), 32'(e_rden[t]));
        if (e_rden[t] != '0) begin
            check_eq("rd_addr", 32'(rd_addr), 32'(e_addr[t]));
        end
        check_eq("busy", 32'(busy), 32'(e_busy[t]));
        check_eq("truncated", 32'(truncated), 32'(e_trunc[t]));
        check_eq("sel", 32'(sel), (d >= 0) ? 32'(e_sel[d]) : 32'd0);
        check_eq("BX", 32'(BX), (d >= 0) ? 32'(e_bx[d]) : 32'd0);
    endtask

    task automatic tick(input logic s, input logic [NM*AW-1:0] nv);
        start = s;
        nent  = nv;
        @(posedge clk);
        t++;
        if (s) begin
            model_start(t, nv);
        end
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle_ticks(input int k);
        for (int i = 0; i < k; i++) begin
            tick(1'b0, {$urandom, $urandom, $urandom});
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check_eq({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check_eq({tag, "_sel"}, 32'(sel), 32'd0);
        check_eq({tag, "_BX"}, 32'(BX), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_truncated"}, 32'(truncated), 32'd0);
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check_zero("reset");
    endtask

    logic [NM*AW-1:0] nv;

    initial begin
        do_reset();

        // All counts zero: header then straight back to idle.
        tick(1'b1, '0);
        idle_ticks(6);

        nv = '0; nv[0*AW +: AW] = 6'd2; nv[3*AW +: AW] = 6'd1;
        tick(1'b1, nv);
        idle_ticks(9);

        nv = '0; nv[9*AW +: AW] = 6'd1; nv[11*AW +: AW] = 6'd1;
        tick(1'b1, nv);
        idle_ticks(7);

        nv = '0; nv[0*AW +: AW] = 6'd20;
        tick(1'b1, nv);
        idle_ticks(13);

        // Abort mid-READ after three reads.
        nv = '0; nv[0*AW +: AW] = 6'd10;
        tick(1'b1, nv);
        idle_ticks(4);
        tick(1'b1, nv);
        idle_ticks(12);

        // Enough back-to-back BXs to wrap the BX counter.
        for (int i = 0; i < 9; i++) begin
            nv = '0; nv[1*AW +: AW] = 6'd1;
            tick(1'b1, nv);
            idle_ticks(1);
        end
        idle_ticks(6);

        nv = '0; nv[0*AW +: AW] = 6'd2; nv[1*AW +: AW] = 6'd2;
        tick(1'b1, nv);
        idle_ticks(8);

        // Asynchronous reset in the middle of READ.
        nv = '0; nv[0*AW +: AW] = 6'd5;
        tick(1'b1, nv);
        idle_ticks(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        check_zero("post_rst");

        for (int n = 0; n < 250; n++) begin
            int gap;
            for (int i = 0; i < NM; i++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 5) begin
                    nv[i*AW +: AW] = 6'd0;
                end else if (r < 9) begin
                    nv[i*AW +: AW] = AW'($urandom_range(1, 4));
                end else begin
                    nv[i*AW +: AW] = AW'($urandom_range(5, 63));
                end
            end
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : WIN + 4;
            tick(1'b1, nv);
            idle_ticks(gap - 1);
        end
        idle_ticks(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
